mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Sequencer for the EX/MEM pipeline register and the MEM-stage data-memory port of the LC-3b pipeline.
//  Decodes the latched opcode, issues read/write requests, and holds the pipeline (stall_req) until done.
//  Runs the two-access LDI/STI indirection: pointer read, then load_addr, then the data access.
//  Returns aligned/sign-extended load data for writeback and flags memory timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles a single request may wait for mem_resp before abort; 0 disables the check
// PORTS
//  clk               in   1   clock, rising edge
//  reset_n           in   1   asynchronous, active-low reset
//  opcode            in   4   lc3b_opcode of packet in EX/MEM register (out_ipacket.opcode)
//  hold              in   1   EX/MEM hold: indirect pointer fetch still pending
//  addr              in   16  effective address (meat_addrgen_out)
//  store_data        in   16  store source (sr_store_out)
//  mem_rdata         in   16  data-memory read data, valid with mem_resp
//  mem_resp          in   1   data-memory completion, one-cycle pulse
//  mem_read          out  1   read request, held until mem_resp
//  mem_write         out  1   write request, held until mem_resp
//  mem_address       out  16  request address
//  mem_wdata         out  16  write data
//  mem_byte_enable   out  2   byte lanes for writes ([1]=high byte)
//  load_addr         out  1   EX/MEM: replace addrgen with mem_rdata (indirect pointer)
//  stall_req         out  1   freeze pipeline registers
//  wb_valid          out  1   one-cycle pulse: wb_data is valid
//  wb_data           out  16  load result
//  mem_err           out  1   sticky: a request timed out; cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0; wait counter 0; wb_data 0.
//  Op classes:
//   - read: LDB 0010, LDW 0110, LDI 1010
//   - write: STB 0011, STW 0111, STI 1011
//   - all other opcodes are non-memory.
//  States:
//   - IDLE:
//     - non-memory op: stay; stall_req=0.
//     - memory op: stall_req=1 combinationally this cycle.
//     - (LDI|STI)&hold -> IND_RD; otherwise -> ACCESS.
//   - IND_RD: mem_read=1, word read at {addr[15:1],0}.
//     - On mem_resp: load_addr=1 that same cycle (Mealy), -> ACCESS.
//     - stall_req=1.
//   - ACCESS: one request at the (now final) addr; stall_req=1.
//     - On mem_resp -> DONE.
//     - Read ops: capture formatted mem_rdata into wb_data on mem_resp.
//   - DONE: stall_req=0 for exactly one cycle, letting the pipeline advance.
//     - wb_valid=1 for read ops; -> IDLE.
//  Request shaping (registered when entering IND_RD/ACCESS; stable until mem_resp):
//   - word ops: mem_address={addr[15:1],1'b0}; mem_byte_enable=2'b11.
//   - STB: mem_address=addr; mem_wdata={store_data[7:0],store_data[7:0]}; mem_byte_enable = addr[0] ? 2'b10 : 2'b01.
//   - LDB: wb_data = sign-extended byte lane (addr[0]=1 -> mem_rdata[15:8], else [7:0]).
//   - LDW/LDI: wb_data = mem_rdata.
//  mem_read and mem_write are never asserted together; drop in the cycle after mem_resp.
//  Wait counter:
//   - resets on each new request, increments each cycle without mem_resp.
//   - On reaching TIMEOUT_CYCLES (if nonzero): drop request, set mem_err, -> DONE with wb_valid=0.
//  Boundaries:
//   - mem_resp in IDLE/DONE is ignored.
//   - mem_resp in the first request cycle is legal (1-cycle memory).
//   - A back-to-back memory op is seen in IDLE the cycle after DONE: no bubble beyond DONE.
//   - reset_n low mid-request aborts immediately; no load_addr or wb_valid is issued.
// TESTING
//  1. LDW addr=0x3001, 2-cycle memory returns 0xBEEF
//     -> mem_address 0x3000, stall 3 cycles, wb_valid with wb_data 0xBEEF.
//  2. STB addr=0x1235, store_data=0x00A7, 1-cycle memory
//     -> mem_wdata 0xA7A7, byte_enable 2'b10, no wb_valid.
//  3. LDB addr=0x0010, rdata=0x1280 -> wb_data 0xFF80.
//     LDB addr=0x0011 -> wb_data 0x0012.
//  4. LDI hold=1, addr=0x4000, pointer read returns 0x5002, bench register reloads addr
//     -> load_addr pulse coincident with mem_resp, second read at 0x5002.
//     STI variant: second access is a write.
//  5. TIMEOUT_CYCLES=8, memory never responds
//     -> request dropped after 8 cycles, mem_err=1, one DONE cycle, wb_valid=0.
//  6. reset_n asserted during ACCESS
//     -> all outputs 0 asynchronously; next op after release completes normally.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage sequencer: drives the data-memory port, runs LDI/STI pointer
// indirection, stalls the pipeline until the access completes, formats load data.
//
// state  | meaning
// IDLE   | waiting for a memory op in EX/MEM
// IND_RD | pointer read for LDI/STI in flight
// ACCESS | final data read/write in flight
// DONE   | one un-stalled cycle so the pipeline advances
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  opcode,
    input  logic        hold,
    input  logic [15:0] addr,
    input  logic [15:0] store_data,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_byte_enable,
    output logic        load_addr,
    output logic        stall_req,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic        mem_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IND_RD = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_LDW = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_STW = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam int CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          op_read, op_byte, lane_hi, wb_pend;

    logic is_rd_op, is_wr_op, is_mem_op, is_byte_op, is_ind_op;
    logic in_req, timeout_hit;
    logic start_req, req_read, req_write, req_byte;
    logic [15:0] req_addr, req_mem_addr, req_wdata;
    logic [1:0]  req_be;
    logic [7:0]  load_lane;
    logic [15:0] load_fmt;

    assign is_rd_op   = (opcode == OP_LDB) || (opcode == OP_LDW) || (opcode == OP_LDI);
    assign is_wr_op   = (opcode == OP_STB) || (opcode == OP_STW) || (opcode == OP_STI);
    assign is_mem_op  = is_rd_op || is_wr_op;
    assign is_byte_op = (opcode == OP_LDB) || (opcode == OP_STB);
    assign is_ind_op  = (opcode == OP_LDI) || (opcode == OP_STI);

    assign in_req      = (state == S_IND_RD) || (state == S_ACCESS);
    assign timeout_hit = TO_EN && in_req && !mem_resp && (wait_cnt == TC_LAST);

    // The final address after a pointer read is mem_rdata itself: EX/MEM only
    // picks it up on the same edge, so addr would still be stale here.
    always_comb begin
        state_nxt = state;
        start_req = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = addr;
        case (state)
            S_IDLE: begin
                if (is_mem_op) begin
                    start_req = 1'b1;
                    if (is_ind_op && hold) begin
                        state_nxt = S_IND_RD;
                        req_read  = 1'b1;
                    end else begin
                        state_nxt = S_ACCESS;
                        req_read  = is_rd_op;
                        req_write = is_wr_op;
                        req_byte  = is_byte_op;
                    end
                end
            end
            S_IND_RD: begin
                if (mem_resp) begin
                    state_nxt = S_ACCESS;
                    start_req = 1'b1;
                    req_addr  = mem_rdata;
                    req_read  = is_rd_op;
                    req_write = is_wr_op;
                end else if (timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_ACCESS: begin
                if (mem_resp || timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign req_mem_addr = req_byte ? req_addr : {req_addr[15:1], 1'b0};
    assign req_wdata    = req_byte ? {2{store_data[7:0]}} : store_data;
    assign req_be       = (req_byte && req_write) ? (req_addr[0] ? 2'b10 : 2'b01) : 2'b11;

    assign load_lane = lane_hi ? mem_rdata[15:8] : mem_rdata[7:0];
    assign load_fmt  = op_byte ? {{8{load_lane[7]}}, load_lane} : mem_rdata;

    assign stall_req = reset_n && (in_req || ((state == S_IDLE) && is_mem_op));
    assign load_addr = (state == S_IND_RD) && mem_resp;
    assign wb_valid  = (state == S_DONE) && wb_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            wait_cnt        <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            wb_data         <= '0;
            wb_pend         <= 1'b0;
            mem_err         <= 1'b0;
            op_read         <= 1'b0;
            op_byte         <= 1'b0;
            lane_hi         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (timeout_hit) begin
                mem_err <= 1'b1;
            end
            if (start_req) begin
                mem_read        <= req_read;
                mem_write       <= req_write;
                mem_address     <= req_mem_addr;
                mem_wdata       <= req_wdata;
                mem_byte_enable <= req_be;
                wait_cnt        <= '0;
                op_read         <= is_rd_op;
                op_byte         <= req_byte;
                lane_hi         <= req_addr[0];
                wb_pend         <= 1'b0;
            end else if (in_req && (mem_resp || timeout_hit)) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end else if (in_req && TO_EN) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if ((state == S_ACCESS) && mem_resp && op_read) begin
                wb_data <= load_fmt;
                wb_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed LC-3b load/store scenarios plus
// randomized op streams against a word-memory reference model.
module tb_mem_stage_ctrl;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_LDW = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_STW = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  opcode = OP_ADD;
    logic        hold = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] store_data = '0;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        mem_read, mem_write, load_addr, stall_req, wb_valid, mem_err;
    logic [15:0] mem_address, mem_wdata, wb_data;
    logic [1:0]  mem_byte_enable;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .hold(hold), .addr(addr),
        .store_data(store_data), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .load_addr(load_addr),
        .stall_req(stall_req), .wb_valid(wb_valid), .wb_data(wb_data), .mem_err(mem_err)
    );

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [15:0] wd;
        logic [1:0]  be;
        bit          ptr;
    } req_t;

    int checks = 0;
    int errors = 0;
    req_t exp_req[$];
    logic [15:0] exp_wb[$];
    logic [15:0] mem_arr [logic [15:0]];

    bit   mute = 1'b0;
    int   fixed_lat = -1;
    int   drops = 0;
    int   last_drop_len = 0;
    req_t last_req;
    logic [15:0] last_wb = '0;
    int   wb_count = 0;
    int   ld_pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        logic [15:0] k;
        k = {a[15:1], 1'b0};
        if (mem_arr.exists(k)) return mem_arr[k];
        return k ^ 16'h5A5A;
    endfunction

    // memory model and request monitor
    initial begin : mem_model
        bit   active;
        bit   fresh;
        req_t cur;
        int   wait_left;
        int   cyc;
        logic [15:0] old;
        active = 0; wait_left = 0; cyc = 0;
        cur.wr = 0; cur.a = '0; cur.wd = '0; cur.be = '0; cur.ptr = 0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            fresh = 0;
            if (mem_resp) begin
                mem_resp = 1'b0;
                active = 0;
            end else if (active && !(mem_read || mem_write)) begin
                active = 0;
                last_drop_len = cyc;
                drops++;
            end
            if (!active && (mem_read || mem_write)) begin
                if (exp_req.size() == 0) begin
                    fail("unexpected_request");
                end else begin
                    cur = exp_req.pop_front();
                    chk("req_is_write", mem_write, cur.wr);
                    chk("req_addr", mem_address, cur.a);
                    if (cur.wr) begin
                        chk("req_wdata", mem_wdata, cur.wd);
                        chk("req_byte_en", mem_byte_enable, cur.be);
                    end
                end
                last_req.wr = mem_write; last_req.a = mem_address;
                last_req.wd = mem_wdata; last_req.be = mem_byte_enable; last_req.ptr = cur.ptr;
                active = 1; fresh = 1; cyc = 0;
                wait_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
            if (active) begin
                cyc++;
                chk("rd_wr_exclusive", mem_read && mem_write, 0);
                if (!fresh)
                    chk("req_stable", {mem_write, mem_address, mem_wdata, mem_byte_enable},
                        {last_req.wr, last_req.a, last_req.wd, last_req.be});
                if (!mute) begin
                    if (wait_left == 0) begin
                        mem_resp = 1'b1;
                        if (mem_write) begin
                            old = mem_rd(mem_address);
                            mem_arr[{mem_address[15:1], 1'b0}] = {
                                mem_byte_enable[1] ? mem_wdata[15:8] : old[15:8],
                                mem_byte_enable[0] ? mem_wdata[7:0]  : old[7:0]};
                            mem_rdata = 16'($urandom);
                        end else begin
                            mem_rdata = mem_rd(mem_address);
                        end
                    end else begin
                        wait_left--;
                    end
                end
            end else begin
                mem_rdata = 16'($urandom);
            end
            #1;
            chk("load_addr", load_addr, mem_resp && active && cur.ptr);
        end
    end

    initial begin : wb_monitor
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                wb_count++;
                last_wb = wb_data;
                if (exp_wb.size() == 0) fail("unexpected_wb_valid");
                else chk("wb_data", wb_data, exp_wb.pop_front());
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] sd,
                         input bit h, input bit resp_ok, output int stalls);
        bit rd, wr, done, reload;
        logic [15:0] fa, w, rv;
        logic [7:0] b;
        int sv;
        req_t r;
        rd = (op == OP_LDB) || (op == OP_LDW) || (op == OP_LDI);
        wr = (op == OP_STB) || (op == OP_STW) || (op == OP_STI);
        fa = a;
        if ((op == OP_LDI || op == OP_STI) && h) begin
            r.wr = 0; r.a = {a[15:1], 1'b0}; r.wd = '0; r.be = 2'b11; r.ptr = 1;
            exp_req.push_back(r);
            fa = mem_rd(a);
        end
        if (rd || wr) begin
            r.wr = wr; r.ptr = 0; r.wd = sd; r.be = 2'b11;
            r.a = (op == OP_STB || op == OP_LDB) ? fa : {fa[15:1], 1'b0};
            if (op == OP_STB) begin
                r.wd = {sd[7:0], sd[7:0]};
                r.be = fa[0] ? 2'b10 : 2'b01;
            end
            exp_req.push_back(r);
        end
        if (rd && resp_ok) begin
            w = mem_rd(fa);
            if (op == OP_LDB) begin
                b = fa[0] ? w[15:8] : w[7:0];
                sv = $signed(b);
                exp_wb.push_back(16'(sv));
            end else begin
                exp_wb.push_back(w);
            end
        end
        @(posedge clk); #1;
        opcode = op; addr = a; store_data = sd; hold = h;
        stalls = 0;
        done = 0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk); #2;
            reload = load_addr;
            rv = mem_rdata;
            if (!stall_req) begin
                done = 1;
            end else begin
                stalls++;
                if (reload) ld_pulses++;
                @(posedge clk); #1;
                if (reload) begin
                    addr = rv;
                    hold = 1'b0;
                end
            end
        end
        if (!done) fail("op_never_completed");
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        opcode = OP_ADD; hold = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        int st, w0, d0, l0;
        logic [3:0] op;
        logic [3:0] mem_ops [6];
        mem_ops = '{OP_LDB, OP_LDW, OP_LDI, OP_STB, OP_STW, OP_STI};

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_mem_address", mem_address, 0);
        reset_n = 1'b1;

        fixed_lat = 1;
        mem_arr[16'h3000] = 16'hBEEF;
        issue(OP_LDW, 16'h3001, 16'h0, 0, 1, st);
        chk("t1_stall_cycles", st, 3);
        chk("t1_mem_address", last_req.a, 16'h3000);
        chk("t1_wb_data", last_wb, 16'hBEEF);

        fixed_lat = 0;
        w0 = wb_count;
        issue(OP_STB, 16'h1235, 16'h00A7, 0, 1, st);
        chk("t2_stall_cycles", st, 2);
        chk("t2_wdata", last_req.wd, 16'hA7A7);
        chk("t2_byte_en", last_req.be, 2'b10);
        chk("t2_no_wb", wb_count, w0);

        fixed_lat = -1;
        mem_arr[16'h0010] = 16'h1280;
        issue(OP_LDB, 16'h0010, 16'h0, 0, 1, st);
        chk("t3_ldb_lo", last_wb, 16'hFF80);
        issue(OP_LDB, 16'h0011, 16'h0, 0, 1, st);
        chk("t3_ldb_hi", last_wb, 16'h0012);

        mem_arr[16'h4000] = 16'h5002;
        mem_arr[16'h5002] = 16'h1357;
        l0 = ld_pulses;
        issue(OP_LDI, 16'h4000, 16'h0, 1, 1, st);
        chk("t4_ldi_final_addr", last_req.a, 16'h5002);
        chk("t4_ldi_wb", last_wb, 16'h1357);
        chk("t4_load_addr_pulses", ld_pulses - l0, 1);
        mem_arr[16'h4002] = 16'h6004;
        issue(OP_STI, 16'h4002, 16'h2468, 1, 1, st);
        chk("t4_sti_is_write", last_req.wr, 1);
        chk("t4_sti_addr", last_req.a, 16'h6004);
        chk("t4_sti_mem", mem_rd(16'h6004), 16'h2468);

        for (int i = 0; i < 200; i++) begin
            bit h;
            logic [15:0] a;
            if ($urandom_range(0, 3) != 0) op = mem_ops[$urandom_range(0, 5)];
            else op = 4'($urandom_range(0, 15));
            a = 16'h3000 + 16'($urandom_range(0, 31));
            h = (op == OP_LDI || op == OP_STI) ? 1'($urandom_range(0, 1)) : 1'b0;
            issue(op, a, 16'($urandom), h, 1, st);
            if (!(op inside {OP_LDB, OP_LDW, OP_LDI, OP_STB, OP_STW, OP_STI}))
                chk("nonmem_no_stall", st, 0);
        end
        chk("rand_mem_err_clear", mem_err, 0);
        idle(2);

        mute = 1'b1;
        d0 = drops;
        w0 = wb_count;
        issue(OP_LDW, 16'h2000, 16'h0, 0, 0, st);
        chk("t5_stall_cycles", st, 9);
        chk("t5_drop_len", last_drop_len, 8);
        chk("t5_drop_count", drops - d0, 1);
        chk("t5_mem_err", mem_err, 1);
        chk("t5_no_wb", wb_count, w0);
        mute = 1'b0;
        issue(OP_LDW, 16'h3004, 16'h0, 0, 1, st);
        chk("t5_mem_err_sticky", mem_err, 1);
        idle(2);

        mute = 1'b1;
        begin
            req_t r;
            r.wr = 0; r.a = 16'h2222; r.wd = '0; r.be = 2'b11; r.ptr = 0;
            exp_req.push_back(r);
        end
        w0 = wb_count;
        @(posedge clk); #1;
        opcode = OP_LDW; addr = 16'h2222;
        repeat (3) @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_mem_read", mem_read, 0);
        chk("t6_stall", stall_req, 0);
        chk("t6_load_addr", load_addr, 0);
        chk("t6_mem_err", mem_err, 0);
        chk("t6_wb_data", wb_data, 0);
        chk("t6_mem_address", mem_address, 0);
        opcode = OP_ADD;
        @(negedge clk);
        mute = 1'b0;
        reset_n = 1'b1;
        mem_arr[16'h3010] = 16'hCAFE;
        issue(OP_LDW, 16'h3010, 16'h0, 0, 1, st);
        chk("t6_after_wb", last_wb, 16'hCAFE);
        chk("t6_after_wb_count", wb_count - w0, 1);
        chk("t6_after_mem_err", mem_err, 0);
        idle(3);

        chk("req_queue_drained", exp_req.size(), 0);
        chk("wb_queue_drained", exp_wb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
